// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two writes (port 1 wins), bypass, zero reg, busy scoreboard.
// Reads are zero-latency; writes and busy updates commit on the rising edge; no backpressure (always accepts).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    regwrite0,
  input  logic [ADDR_W-1:0]       wr0,
  input  logic [DATA_W-1:0]       write_data0,
  input  logic                    regwrite1,
  input  logic [ADDR_W-1:0]       wr1,
  input  logic [DATA_W-1:0]       write_data1,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  input  logic [NREAD*ADDR_W-1:0] rr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  output logic [2**ADDR_W-1:0]    busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              we0;
  logic              we1;
  logic              rsv_ok;

  // Port 0 is dropped when port 1 targets the same index; index 0 is read-only when hardwired.
  assign we1    = regwrite1 && !((ZERO_REG != 0) && (wr1 == '0));
  assign we0    = regwrite0 && !((ZERO_REG != 0) && (wr0 == '0))
                            && !(regwrite1 && (wr1 == wr0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[wr0] <= write_data0;
      if (we1) regs[wr1] <= write_data1;
    end
  end

  // A reservation beats a same-cycle write: a newer producer is still outstanding.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_ok && (rsv_addr == ADDR_W'(i)))
        busy_nxt[i] = 1'b1;
      else if ((we0 && (wr0 == ADDR_W'(i))) || (we1 && (wr1 == ADDR_W'(i))))
        busy_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;

    assign a = rr[k*ADDR_W +: ADDR_W];

    always_comb begin
      v = regs[a];
      if (BYPASS != 0) begin
        if (regwrite1 && (wr1 == a))      v = write_data1;
        else if (regwrite0 && (wr0 == a)) v = write_data0;
      end
      // Masks bypass of a hardwired zero and of writes presented while reset is held.
      if ((ZERO_REG != 0) && (a == '0)) v = '0;
      if (!reset)                       v = '0;
    end

    assign rdata[k*DATA_W +: DATA_W] = v;
    assign rbusy[k]                  = busy[a];
  end

endmodule
